// File: rtl/cpu_pkg.sv
// Shared CPU definitions: exception codes, handler vector and the stage record.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int unsigned EXC_W = 5;

    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

    localparam logic [31:0] VEC_PC_DEFAULT = 32'h0000_4180;

    // Architectural fields every pipeline stage carries alongside its payload.
    typedef struct packed {
        logic             valid;
        logic [31:0]      pc;
        logic             bd;
        logic [EXC_W-1:0] exc;
    } stage_rec_t;

endpackage

// File: rtl/pipe_stage_slice.sv
// One pipeline register slice with vector-clear, bubble and load controls.
// Latency: 1 cycle from d_* to q_* when load=1.
// Backpressure: load=0 holds the slice; clr_vec beats bubble beats load.
// Ports: clk/reset (async active-low); clr_vec, bubble, load controls;
//        d_* next-slice inputs; q_* registered slice contents.
module pipe_stage_slice
    import cpu_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 96,
    parameter int unsigned EXC_W     = cpu_pkg::EXC_W,
    parameter logic [31:0] VEC_PC    = cpu_pkg::VEC_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr_vec,
    input  logic                 bubble,
    input  logic                 load,
    input  logic                 d_valid,
    input  logic [31:0]          d_pc,
    input  logic                 d_bd,
    input  logic [PAYLOAD_W-1:0] d_payload,
    input  logic [EXC_W-1:0]     d_exc,
    output logic                 q_valid,
    output logic [31:0]          q_pc,
    output logic                 q_bd,
    output logic [PAYLOAD_W-1:0] q_payload,
    output logic [EXC_W-1:0]     q_exc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_valid   <= 1'b0;
            q_pc      <= 32'd0;
            q_bd      <= 1'b0;
            q_payload <= '0;
            q_exc     <= '0;
        end else if (clr_vec) begin
            // Exception entry: kill the slice but leave the handler PC behind.
            q_valid   <= 1'b0;
            q_pc      <= VEC_PC;
            q_bd      <= 1'b0;
            q_payload <= '0;
            q_exc     <= '0;
        end else if (bubble) begin
            q_valid   <= 1'b0;
            q_pc      <= 32'd0;
            q_bd      <= 1'b0;
            q_payload <= '0;
            q_exc     <= '0;
        end else if (load) begin
            q_valid   <= d_valid;
            q_pc      <= d_pc;
            q_bd      <= d_bd;
            q_payload <= d_payload;
            q_exc     <= d_exc;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register (DEPTH slices) with exception merge.
// Latency: DEPTH cycles input to output while en=1.
// Backpressure: en=0 stalls all slices; flush bubbles slice 0; req clears all to VEC_PC.
// Ports: clk, reset (async active-low), en/flush/req controls, *_in producer fields,
//        exc_src/exc_codes new exception sources, *_out last-slice fields, pc8_out link.
// Optional: PIPE_STAGE_PERF_EN adds stall_cnt, bubble_cnt, req_cnt saturating counters.
module pipe_stage_reg #(
    parameter int unsigned PAYLOAD_W = 96,
    parameter int unsigned DEPTH     = 1,
    parameter int unsigned EXC_SRCS  = 3,
    parameter int unsigned EXC_W     = cpu_pkg::EXC_W,
    parameter logic [31:0] VEC_PC    = cpu_pkg::VEC_PC_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      flush,
    input  logic                      req,
    input  logic                      valid_in,
    input  logic [31:0]               pc_in,
    input  logic                      bd_in,
    input  logic [PAYLOAD_W-1:0]      payload_in,
    input  logic [EXC_W-1:0]          exc_in,
    input  logic [EXC_SRCS-1:0]       exc_src,
    input  logic [EXC_SRCS*EXC_W-1:0] exc_codes,
    output logic                      valid_out,
    output logic [31:0]               pc_out,
    output logic [31:0]               pc8_out,
    output logic                      bd_out,
    output logic [PAYLOAD_W-1:0]      payload_out,
    output logic [EXC_W-1:0]          exc_out
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]               stall_cnt,
    output logic [31:0]               bubble_cnt,
    output logic [15:0]               req_cnt
`endif
);
    import cpu_pkg::*;

    logic [EXC_W-1:0] src_code;
    logic [EXC_W-1:0] merged_exc;

    // Upstream code wins; otherwise lowest-index asserted source. A bubble
    // never carries an exception.
    always_comb begin
        src_code = '0;
        for (int i = EXC_SRCS - 1; i >= 0; i--) begin
            if (exc_src[i]) src_code = exc_codes[i*EXC_W +: EXC_W];
        end
        merged_exc = '0;
        if (valid_in) merged_exc = (exc_in != '0) ? exc_in : src_code;
    end

    logic [DEPTH-1:0]                d_valid, q_valid;
    logic [DEPTH-1:0][31:0]          d_pc, q_pc;
    logic [DEPTH-1:0]                d_bd, q_bd;
    logic [DEPTH-1:0][PAYLOAD_W-1:0] d_payload, q_payload;
    logic [DEPTH-1:0][EXC_W-1:0]     d_exc, q_exc;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slice
        if (k == 0) begin : g_head
            assign d_valid[k]   = valid_in;
            assign d_pc[k]      = pc_in;
            assign d_bd[k]      = bd_in;
            assign d_payload[k] = payload_in;
            assign d_exc[k]     = merged_exc;
        end else begin : g_tail
            assign d_valid[k]   = q_valid[k-1];
            assign d_pc[k]      = q_pc[k-1];
            assign d_bd[k]      = q_bd[k-1];
            assign d_payload[k] = q_payload[k-1];
            assign d_exc[k]     = q_exc[k-1];
        end

        // Flush only bubbles the head; deeper slices keep following en.
        pipe_stage_slice #(
            .PAYLOAD_W (PAYLOAD_W),
            .EXC_W     (EXC_W),
            .VEC_PC    (VEC_PC)
        ) u_slice (
            .clk       (clk),
            .reset     (reset),
            .clr_vec   (req),
            .bubble    ((k == 0) ? flush : 1'b0),
            .load      (en),
            .d_valid   (d_valid[k]),
            .d_pc      (d_pc[k]),
            .d_bd      (d_bd[k]),
            .d_payload (d_payload[k]),
            .d_exc     (d_exc[k]),
            .q_valid   (q_valid[k]),
            .q_pc      (q_pc[k]),
            .q_bd      (q_bd[k]),
            .q_payload (q_payload[k]),
            .q_exc     (q_exc[k])
        );
    end

    assign valid_out   = q_valid[DEPTH-1];
    assign pc_out      = q_pc[DEPTH-1];
    assign bd_out      = q_bd[DEPTH-1];
    assign payload_out = q_payload[DEPTH-1];
    assign exc_out     = q_exc[DEPTH-1];
    assign pc8_out     = q_pc[DEPTH-1] + 32'd8;  // wraps modulo 2^32

`ifdef PIPE_STAGE_PERF_EN
    logic stall_ev, bubble_ev;
    assign stall_ev  = !en && !req && !flush;
    assign bubble_ev = !req && (flush || (en && !valid_in));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= 32'd0;
            bubble_cnt <= 32'd0;
            req_cnt    <= 16'd0;
        end else begin
            if (stall_ev && !(&stall_cnt))   stall_cnt  <= stall_cnt + 32'd1;
            if (bubble_ev && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + 32'd1;
            if (req && !(&req_cnt))          req_cnt    <= req_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (DEPTH=2) against a slice-array model.
// Latency: model updated on each rising edge, outputs sampled 1 time unit later.
// Backpressure: exercised through random en/flush/req plus directed cases.
module tb_pipe_stage_reg;
    localparam int PW = 96;
    localparam int D  = 2;
    localparam int NS = 3;
    localparam int EW = 5;
    localparam logic [31:0] VEC = 32'h0000_4180;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           en = 1'b0, flush = 1'b0, req = 1'b0;
    logic           valid_in = 1'b0, bd_in = 1'b0;
    logic [31:0]    pc_in = '0;
    logic [PW-1:0]  payload_in = '0;
    logic [EW-1:0]  exc_in = '0;
    logic [NS-1:0]  exc_src = '0;
    logic [NS*EW-1:0] exc_codes = '0;
    logic           valid_out, bd_out;
    logic [31:0]    pc_out, pc8_out;
    logic [PW-1:0]  payload_out;
    logic [EW-1:0]  exc_out;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt, bubble_cnt;
    logic [15:0] req_cnt;
    int unsigned m_stall = 0, m_bubble = 0, m_req = 0;
`endif

    pipe_stage_reg #(.PAYLOAD_W(PW), .DEPTH(D), .EXC_SRCS(NS), .EXC_W(EW), .VEC_PC(VEC)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .req(req),
        .valid_in(valid_in), .pc_in(pc_in), .bd_in(bd_in), .payload_in(payload_in),
        .exc_in(exc_in), .exc_src(exc_src), .exc_codes(exc_codes),
        .valid_out(valid_out), .pc_out(pc_out), .pc8_out(pc8_out), .bd_out(bd_out),
        .payload_out(payload_out), .exc_out(exc_out)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .req_cnt(req_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [31:0]   pc;
        logic          bd;
        logic [PW-1:0] pl;
        logic [EW-1:0] exc;
    } rec_t;

    rec_t m[D];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] exp_exc();
        if (!valid_in) return '0;
        if (exc_in != '0) return exc_in;
        for (int i = 0; i < NS; i++)
            if (exc_src[i]) return exc_codes[i*EW +: EW];
        return '0;
    endfunction

    function automatic rec_t zero_rec(input logic [31:0] pc);
        rec_t r;
        r.v = 1'b0; r.pc = pc; r.bd = 1'b0; r.pl = '0; r.exc = '0;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < D; k++) m[k] = zero_rec(32'd0);
`ifdef PIPE_STAGE_PERF_EN
        m_stall = 0; m_bubble = 0; m_req = 0;
`endif
    endtask

    task automatic model_edge();
        rec_t r;
`ifdef PIPE_STAGE_PERF_EN
        if (!en && !req && !flush) m_stall++;
        if (!req && (flush || (en && !valid_in))) m_bubble++;
        if (req) m_req++;
`endif
        if (req) begin
            for (int k = 0; k < D; k++) m[k] = zero_rec(VEC);
        end else begin
            if (en) for (int k = D - 1; k > 0; k--) m[k] = m[k-1];
            if (flush) m[0] = zero_rec(32'd0);
            else if (en) begin
                r.v = valid_in; r.pc = pc_in; r.bd = bd_in; r.pl = payload_in; r.exc = exp_exc();
                m[0] = r;
            end
        end
    endtask

    task automatic compare_all();
        chk("valid_out", 128'(valid_out), 128'(m[D-1].v));
        chk("pc_out", 128'(pc_out), 128'(m[D-1].pc));
        chk("pc8_out", 128'(pc8_out), 128'(32'(m[D-1].pc + 32'd8)));
        chk("bd_out", 128'(bd_out), 128'(m[D-1].bd));
        chk("payload_out", 128'(payload_out), 128'(m[D-1].pl));
        chk("exc_out", 128'(exc_out), 128'(m[D-1].exc));
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
        chk("bubble_cnt", 128'(bubble_cnt), 128'(m_bubble));
        chk("req_cnt", 128'(req_cnt), 128'(m_req));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        logic [PW-1:0] pat;
        model_reset();
        #2;
        compare_all();
        chk("reset_pc8", 128'(pc8_out), 128'(32'd8));
        @(negedge clk);
        reset = 1'b1;

        // Basic flow
        pat = {12{8'hA5}};
        en = 1'b1; valid_in = 1'b1; pc_in = 32'h3000; payload_in = pat;
        repeat (D) tick();
        chk("flow_valid", 128'(valid_out), 128'(1'b1));
        chk("flow_pc", 128'(pc_out), 128'(32'h3000));
        chk("flow_pc8", 128'(pc8_out), 128'(32'h3008));
        chk("flow_payload", 128'(payload_out), 128'(pat));

        // Exception merge priority: source2=12, source1=5, source0=4
        exc_codes = {5'd12, 5'd5, 5'd4};
        exc_in = '0; exc_src = 3'b110;
        repeat (D) tick();
        chk("merge_src1", 128'(exc_out), 128'(5'd5));
        exc_in = 5'd4; exc_src = 3'b111;
        repeat (D) tick();
        chk("merge_upstream", 128'(exc_out), 128'(5'd4));
        valid_in = 1'b0; exc_in = '0; exc_src = 3'b001;
        repeat (D) tick();
        chk("merge_bubble", 128'(exc_out), 128'(5'd0));

        // Stall with changing inputs
        valid_in = 1'b1; pc_in = 32'h5000; exc_src = '0;
        repeat (D) tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'h6000 + 32'(i * 4);
            tick();
            chk("stall_frozen_pc", 128'(pc_out), 128'(32'h5000));
        end
        en = 1'b1;
        repeat (D) tick();
        chk("resume_pc", 128'(pc_out), 128'(32'h6008));

        // Flush during stall: head bubbles, tail holds
        pc_in = 32'h7000;
        repeat (D) tick();
        en = 1'b0; flush = 1'b1;
        tick();
        chk("flush_tail_hold", 128'(valid_out), 128'(1'b1));
        en = 1'b1; flush = 1'b0;
        tick();
        chk("flush_bubble_out", 128'(valid_out), 128'(1'b0));

        // req beats flush and stall
        repeat (D) tick();
        req = 1'b1; flush = 1'b1; en = 1'b0;
        tick();
        chk("req_valid", 128'(valid_out), 128'(1'b0));
        chk("req_pc", 128'(pc_out), 128'(VEC));
        chk("req_exc", 128'(exc_out), 128'(5'd0));
        chk("req_payload", 128'(payload_out), 128'(96'd0));
        req = 1'b0; flush = 1'b0; en = 1'b1;

        // Async reset between edges
        payload_in = {$urandom, $urandom, $urandom};
        repeat (D) tick();
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("areset_pc8", 128'(pc8_out), 128'(32'd8));
        @(negedge clk);
        reset = 1'b1;

        // PC wrap on link value
        pc_in = 32'hFFFF_FFFC;
        repeat (D) tick();
        chk("pc8_wrap", 128'(pc8_out), 128'(32'h0000_0004));

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            en         = ($urandom_range(3) != 0);
            flush      = ($urandom_range(9) == 0);
            req        = ($urandom_range(19) == 0);
            valid_in   = ($urandom_range(3) != 0);
            bd_in      = 1'($urandom);
            pc_in      = $urandom;
            payload_in = {$urandom, $urandom, $urandom};
            exc_in     = ($urandom_range(1) == 0) ? '0 : 5'($urandom);
            exc_src    = 3'($urandom);
            exc_codes  = 15'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
